// File: rtl/parity_frame_ctrl.sv
// Serialises a WIDTH-bit word LSB first, then appends an even/odd parity bit.
// Valid/ready on both sides, with a wrapping count of completed frames.
//
// state  | meaning
// IDLE   | waiting for a word, in_ready high
// SHIFT  | presenting data bits, shreg[0] on ser_out
// PARITY | presenting the accumulated parity bit, ser_last high
module parity_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             odd_sel,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last,
    output logic             par_out,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic             acc;
    logic [BW-1:0]    bit_cnt;
    logic             done_q;
    logic             par_q;
    logic [CNT_W-1:0] cnt_q;

    // acc is seeded with the parity sense, so it ends as XOR(data) ^ mode
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            acc     <= 1'b0;
            bit_cnt <= '0;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg   <= in_data;
                        acc     <= odd_sel;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ser_ready) begin
                        acc     <= acc ^ shreg[0];
                        shreg   <= {1'b0, shreg[WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(WIDTH - 1))
                            state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (ser_ready) begin
                        par_q  <= acc;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ser_out = 1'b0;
        if (state == S_SHIFT)
            ser_out = shreg[0];
        else if (state == S_PARITY)
            ser_out = acc;
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_SHIFT) || (state == S_PARITY);
    assign ser_valid = busy;
    assign ser_last  = (state == S_PARITY);
    assign par_out   = par_q;
    assign done      = done_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl: bit order, parity sense, stalls,
// back-to-back frames, mid-frame reset and frame counter wrap.
module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       odd_sel;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_out;
    logic       ser_last;
    logic       par_out;
    logic       done;
    logic       busy;
    logic [7:0] frame_cnt;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt  = 8'd0;

    parity_frame_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .odd_sel   (odd_sel),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_out   (ser_out),
        .ser_last  (ser_last),
        .par_out   (par_out),
        .done      (done),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in the cycle where done is high.
    task automatic run_frame(input string tag, input logic [3:0] d, input logic odd,
                             input logic [3:0] bits, input logic par,
                             input int stall_at, input int stall_n, input logic keep_valid);
        in_data  = d;
        odd_sel  = odd;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, in_ready, 1);
        tick();
        if (!keep_valid) in_valid = 1'b0;
        in_data = ~d;
        odd_sel = ~odd;
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                ser_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk($sformatf("%s.stall_valid%0d", tag, s), ser_valid, 1);
                    chk($sformatf("%s.stall_out%0d", tag, s), ser_out, bits[i]);
                    tick();
                end
                ser_ready = 1'b1;
            end
            chk($sformatf("%s.valid%0d", tag, i), ser_valid, 1);
            chk($sformatf("%s.bit%0d", tag, i), ser_out, bits[i]);
            chk($sformatf("%s.last%0d", tag, i), ser_last, 0);
            chk($sformatf("%s.busy%0d", tag, i), busy, 1);
            tick();
        end
        odd_sel = odd;
        chk({tag, ".par_last"}, ser_last, 1);
        chk({tag, ".par_bit"}, ser_out, par);
        chk({tag, ".par_done_early"}, done, 0);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".par_out"}, par_out, par);
        chk({tag, ".frame_cnt"}, frame_cnt, exp_cnt);
        chk({tag, ".idle_ready"}, in_ready, 1);
        chk({tag, ".idle_valid"}, ser_valid, 0);
        chk({tag, ".idle_out"}, ser_out, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        odd_sel   = 1'b0;
        ser_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.ser_valid", ser_valid, 0);
        chk("rst.ser_out", ser_out, 0);
        chk("rst.ser_last", ser_last, 0);
        chk("rst.done", done, 0);
        chk("rst.busy", busy, 0);
        chk("rst.par_out", par_out, 0);
        chk("rst.frame_cnt", frame_cnt, 0);

        // even parity on 0110
        run_frame("t1", 4'b0110, 1'b0, 4'b0110, 1'b0, -1, 0, 1'b0);
        tick();
        chk("t1.done_one_cycle", done, 0);
        chk("t1.par_held", par_out, 0);

        // 0111 odd then even
        run_frame("t2o", 4'b0111, 1'b1, 4'b0111, 1'b0, -1, 0, 1'b0);
        tick();
        run_frame("t2e", 4'b0111, 1'b0, 4'b0111, 1'b1, -1, 0, 1'b0);
        tick();

        // stall three cycles on bit index 2
        run_frame("t3", 4'b1011, 1'b0, 4'b1011, 1'b1, 2, 3, 1'b0);
        tick();
        chk("t3.done_one_cycle", done, 0);

        // back-to-back with in_valid held high
        run_frame("t4a", 4'b0001, 1'b0, 4'b0001, 1'b1, -1, 0, 1'b1);
        run_frame("t4b", 4'b1111, 1'b1, 4'b1111, 1'b1, -1, 0, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("t4.idle_after", busy, 0);

        // reset while bit index 2 is presented
        in_data  = 4'b0110;
        odd_sel  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5.pre_bit2", ser_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 8'd0;
        chk("t5.ser_valid", ser_valid, 0);
        chk("t5.busy", busy, 0);
        chk("t5.in_ready", in_ready, 1);
        chk("t5.frame_cnt", frame_cnt, 0);
        chk("t5.par_out", par_out, 0);
        chk("t5.done", done, 0);
        tick();
        chk("t5.no_done", done, 0);
        chk("t5.still_idle", ser_valid, 0);
        run_frame("t5f", 4'b1010, 1'b1, 4'b1010, 1'b1, -1, 0, 1'b0);
        tick();

        // 256 frames of zero data, odd parity, counter wraps
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 8'd0;
        for (int f = 1; f <= 256; f++) begin
            run_frame($sformatf("t6.f%0d", f), 4'b0000, 1'b1, 4'b0000, 1'b1, -1, 0, 1'b0);
            if (f == 255) chk("t6.cnt255", frame_cnt, 255);
            if (f == 256) chk("t6.cnt_wrap", frame_cnt, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
Sequencer that serialises a parallel data word and appends a generated parity bit. The parity sense is selectable per frame: 0 = even, 1 = odd. It sits between a parallel producer (valid/ready) and a serial consumer (valid/ready). It wraps the team's 4-bit even/odd parity generator function in a clocked, flow-controlled frame controller. It also keeps a running frame count.

Parameters:
WIDTH, 4, number of data bits per frame (>=2)
CNT_W, 8, width of the completed-frame counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller can accept a word (state IDLE)
in_data  input  WIDTH  parallel data word, sent LSB first
odd_sel  input  1  parity sense sampled with the word: 0 even, 1 odd
ser_valid  output  1  ser_out carries a frame bit
ser_ready  input  1  consumer accepts the current bit
ser_out  output  1  serial bit (data bits, then parity bit)
ser_last  output  1  high while the parity bit is presented
par_out  output  1  parity bit of the last completed frame, held until next completion
done  output  1  one-cycle pulse after the parity bit is accepted
busy  output  1  frame in progress (state SHIFT or PARITY)
frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered or decoded from state registers only. No combinational path from any input to any output.
- Reset, and the cycle after any rst-high edge:
  - state = IDLE, in_ready = 1.
  - ser_valid = ser_out = ser_last = 0.
  - done = busy = par_out = 0, frame_cnt = 0.
- States: IDLE, SHIFT, PARITY.
- IDLE:
  - in_ready = 1, ser_valid = 0.
  - Accept happens on an edge where in_valid & in_ready = 1. On accept:
    - shift register <= in_data.
    - mode <= odd_sel.
    - accumulator <= odd_sel.
    - bit_cnt <= 0.
    - go to SHIFT.
- SHIFT:
  - ser_valid = 1, ser_out = shreg[0], busy = 1.
  - On an edge with ser_ready = 1:
    - acc ^= shreg[0].
    - Shift right.
    - bit_cnt++.
    - If bit_cnt == WIDTH-1, go to PARITY.
  - With ser_ready = 0, all state holds and ser_out stays stable.
- PARITY:
  - ser_valid = 1, ser_out = acc, ser_last = 1.
  - On an edge with ser_ready = 1:
    - par_out <= acc.
    - frame_cnt++.
    - done = 1 for the next cycle only.
    - Go to IDLE.
- Parity rule: P = XOR(data bits) XOR mode. Total ones in the frame is even for mode 0 and odd for mode 1.
- Latency and throughput, with ser_ready held high and accept at edge k:
  - Data bits in cycles k+1..k+WIDTH.
  - Parity bit in cycle k+WIDTH+1.
  - done and in_ready high in cycle k+WIDTH+2.
  - Maximum rate is one frame per WIDTH+2 cycles.
- in_data and odd_sel are ignored outside the accept edge. Changes mid-frame have no effect.
- ser_out = 0 whenever ser_valid = 0.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-frame aborts the frame. No done pulse, par_out and frame_cnt are cleared, and no further serial bits are emitted.
- rst has priority over every handshake on the same edge.

Test Plan:
1. WIDTH=4, odd_sel=0, in_data=4'b0110, ser_ready=1 -> ser_out 0,1,1,0 then parity 0 with ser_last=1; done pulses at cycle k+6; par_out=0, frame_cnt=1.
2. odd_sel=1, in_data=4'b0111 -> bits 1,1,1,0, parity 0. Repeat with odd_sel=0 -> parity 1.
3. in_data=4'b1011, odd_sel=0, ser_ready low for 3 cycles while bit index 2 is presented -> ser_out=0 and ser_valid=1 held for all 3 cycles; the frame still contains exactly 5 bits 1,1,0,1,1; done one cycle after the parity bit is accepted.
4. Back-to-back frames: in_valid held high with 4'b0001 then 4'b1111; toggle odd_sel mid-frame, and sample odd_sel=1 at the second accept -> exactly one idle cycle (in_ready=1) between frames; first parity 1 (even), second parity 1 (odd).
5. rst pulsed for one cycle while data bit 2 is presented -> next cycle ser_valid=0, busy=0, in_ready=1, frame_cnt=0; no done pulse; the next frame is transmitted correctly.
6. CNT_W=8: 256 frames of in_data=4'b0000, odd_sel=1 -> every parity bit is 1; frame_cnt reads 255 then wraps to 0 on frame 256.
